// File: rtl/fft_sequencer.sv
// Control sequencer for the 32-point FFT datapath: load, 5x16 butterfly issue
// with pipeline drain between stages, then unload. All outputs are registered.
module fft_sequencer #(
   parameter int BFLY_LAT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       sample_valid,
   output logic       sample_ready,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [1:0] input_mode,
   output logic [4:0] samples_in_count,
   output logic [4:0] samples_out_count,
   output logic [3:0] iteration_count,
   output logic [2:0] stage_count,
   output logic       bfly_issue,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_UNLOAD  = 3'd4;

   // DRAIN exits when the counter is 0, so loading LAT-1 gives LAT drain cycles.
   localparam logic [3:0] DRAIN_INIT = 4'((BFLY_LAT > 0) ? BFLY_LAT - 1 : 0);

   logic [2:0] state_q, state_d;
   logic [4:0] in_cnt_q, in_cnt_d;
   logic [4:0] out_cnt_q, out_cnt_d;
   logic [3:0] iter_q, iter_d;
   logic [2:0] stage_q, stage_d;
   logic [3:0] drain_q, drain_d;
   logic [1:0] mode_q, mode_d;
   logic       sready_q, sready_d;
   logic       ovalid_q, ovalid_d;
   logic       issue_q, issue_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       advance;

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      iter_d    = iter_q;
      stage_d   = stage_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      advance   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (sample_valid) begin
               if (in_cnt_q == 5'd31) begin
                  state_d  = S_COMPUTE;
                  in_cnt_d = 5'd0;
                  iter_d   = 4'd0;
                  stage_d  = 3'd0;
               end else begin
                  in_cnt_d = in_cnt_q + 5'd1;
               end
            end
         end
         S_COMPUTE: begin
            if (iter_q == 4'd15) begin
               if (BFLY_LAT == 0) begin
                  advance = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = DRAIN_INIT;
               end
            end else begin
               iter_d = iter_q + 4'd1;
            end
         end
         S_DRAIN: begin
            if (drain_q == 4'd0) advance = 1'b1;
            else                 drain_d = drain_q - 4'd1;
         end
         S_UNLOAD: begin
            if (out_ready) begin
               if (out_cnt_q == 5'd31) begin
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
                  in_cnt_d  = 5'd0;
                  out_cnt_d = 5'd0;
                  iter_d    = 4'd0;
                  stage_d   = 3'd0;
               end else begin
                  out_cnt_d = out_cnt_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Shared end-of-stage rule for both the drain exit and the zero-latency path.
      if (advance) begin
         if (stage_q == 3'd4) begin
            state_d   = S_UNLOAD;
            out_cnt_d = 5'd0;
         end else begin
            state_d = S_COMPUTE;
            stage_d = stage_q + 3'd1;
            iter_d  = 4'd0;
         end
      end

      mode_d   = 2'b00;
      case (state_d)
         S_LOAD:              mode_d = 2'b01;
         S_COMPUTE, S_DRAIN:  mode_d = 2'b10;
         S_UNLOAD:            mode_d = 2'b11;
         default:             mode_d = 2'b00;
      endcase
      sready_d = (state_d == S_LOAD);
      ovalid_d = (state_d == S_UNLOAD);
      issue_d  = (state_d == S_COMPUTE);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= 5'd0;
         out_cnt_q <= 5'd0;
         iter_q    <= 4'd0;
         stage_q   <= 3'd0;
         drain_q   <= 4'd0;
         mode_q    <= 2'b00;
         sready_q  <= 1'b0;
         ovalid_q  <= 1'b0;
         issue_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         iter_q    <= iter_d;
         stage_q   <= stage_d;
         drain_q   <= drain_d;
         mode_q    <= mode_d;
         sready_q  <= sready_d;
         ovalid_q  <= ovalid_d;
         issue_q   <= issue_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sample_ready      = sready_q;
   assign out_valid         = ovalid_q;
   assign input_mode        = mode_q;
   assign samples_in_count  = in_cnt_q;
   assign samples_out_count = out_cnt_q;
   assign iteration_count   = iter_q;
   assign stage_count       = stage_q;
   assign bfly_issue        = issue_q;
   assign busy              = busy_q;
   assign done              = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: one instance at BFLY_LAT=3 and one at
// BFLY_LAT=0, driven by the same stimulus and checked against hand-computed values.
module tb_fft_sequencer;

   logic clk = 1'b0;
   logic rst, start, sample_valid, out_ready;

   logic       sample_ready_3, out_valid_3, bfly_issue_3, busy_3, done_3;
   logic [1:0] input_mode_3;
   logic [4:0] samples_in_count_3, samples_out_count_3;
   logic [3:0] iteration_count_3;
   logic [2:0] stage_count_3;

   logic       sample_ready_0, out_valid_0, bfly_issue_0, busy_0, done_0;
   logic [1:0] input_mode_0;
   logic [4:0] samples_in_count_0, samples_out_count_0;
   logic [3:0] iteration_count_0;
   logic [2:0] stage_count_0;

   int checks = 0;
   int errors = 0;
   int cnt, found;
   int ld3, is3, gp3, ul3, dn3, is0, gp0, dn0;

   always #5 clk = ~clk;

   fft_sequencer #(.BFLY_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
      .sample_ready(sample_ready_3), .out_ready(out_ready), .out_valid(out_valid_3),
      .input_mode(input_mode_3), .samples_in_count(samples_in_count_3),
      .samples_out_count(samples_out_count_3), .iteration_count(iteration_count_3),
      .stage_count(stage_count_3), .bfly_issue(bfly_issue_3), .busy(busy_3), .done(done_3)
   );

   fft_sequencer #(.BFLY_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
      .sample_ready(sample_ready_0), .out_ready(out_ready), .out_valid(out_valid_0),
      .input_mode(input_mode_0), .samples_in_count(samples_in_count_0),
      .samples_out_count(samples_out_count_0), .iteration_count(iteration_count_0),
      .stage_count(stage_count_0), .bfly_issue(bfly_issue_0), .busy(busy_0), .done(done_0)
   );

   // Packed views: every output, compute-phase fields, unload-phase fields.
   logic [23:0] all3, all0;
   logic [14:0] cmp3, cmp0;
   logic [8:0]  un3, un0;
   assign all3 = {sample_ready_3, out_valid_3, input_mode_3, samples_in_count_3, samples_out_count_3,
                  iteration_count_3, stage_count_3, bfly_issue_3, busy_3, done_3};
   assign all0 = {sample_ready_0, out_valid_0, input_mode_0, samples_in_count_0, samples_out_count_0,
                  iteration_count_0, stage_count_0, bfly_issue_0, busy_0, done_0};
   assign cmp3 = {input_mode_3, bfly_issue_3, stage_count_3, iteration_count_3, samples_in_count_3};
   assign cmp0 = {input_mode_0, bfly_issue_0, stage_count_0, iteration_count_0, samples_in_count_0};
   assign un3  = {input_mode_3, out_valid_3, samples_out_count_3, done_3};
   assign un0  = {input_mode_0, out_valid_0, samples_out_count_0, done_0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sample_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_all3", 32'(all3), 32'd0);
      chk("rst_all0", 32'(all0), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_all3", 32'(all3), 32'd0);
         chk("idle_all0", 32'(all0), 32'd0);
      end

      // start and sample_valid together in IDLE: the sample is not counted
      start = 1'b1; sample_valid = 1'b1;
      @(negedge clk);
      chk("load_entry3", 32'({input_mode_3, sample_ready_3, samples_in_count_3, busy_3}), 32'({2'd1, 1'b1, 5'd0, 1'b1}));
      chk("load_entry0", 32'({input_mode_0, sample_ready_0, samples_in_count_0, busy_0}), 32'({2'd1, 1'b1, 5'd0, 1'b1}));
      start = 1'b0;

      // sample_valid on odd cycles only: 64 LOAD cycles for 32 accepts
      for (int k = 0; k < 64; k++) begin
         sample_valid = (k % 2 == 1);
         @(negedge clk);
         if (k < 63) begin
            chk("load_cnt3", 32'({input_mode_3, samples_in_count_3}), 32'({2'd1, 5'((k + 1) / 2)}));
            chk("load_cnt0", 32'({input_mode_0, samples_in_count_0}), 32'({2'd1, 5'((k + 1) / 2)}));
         end
      end

      // compute: start and sample_valid held high must be ignored
      start = 1'b1; sample_valid = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 95; c++) begin
         if (c != 0) @(negedge clk);
         if (c % 19 < 16)
            chk("cmp3", 32'(cmp3), 32'({2'd2, 1'b1, 3'(c / 19), 4'(c % 19), 5'd0}));
         else
            chk("drain3", 32'(cmp3), 32'({2'd2, 1'b0, 3'(c / 19), 4'd15, 5'd0}));
         if (c < 80)
            chk("cmp0", 32'(cmp0), 32'({2'd2, 1'b1, 3'(c / 16), 4'(c % 16), 5'd0}));
         else
            chk("wait_unl0", 32'(un0), 32'({2'd3, 1'b1, 5'd0, 1'b0}));
      end
      start = 1'b0;

      // unload with a 5-cycle stall in the middle; both instances in lockstep
      cnt = 0;
      for (int k = 0; k < 37; k++) begin
         @(negedge clk);
         chk("unl3", 32'(un3), 32'({2'd3, 1'b1, 5'(cnt), 1'b0}));
         chk("unl0", 32'(un0), 32'({2'd3, 1'b1, 5'(cnt), 1'b0}));
         out_ready = !(k >= 10 && k < 15);
         if (out_ready) cnt++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      chk("done3", 32'(all3), 32'd1);
      chk("done0", 32'(all0), 32'd1);
      @(negedge clk);
      chk("post_done3", 32'(all3), 32'd0);
      chk("post_done0", 32'(all0), 32'd0);

      // mid-frame reset at stage 2 iteration 7 of the BFLY_LAT=3 instance
      start = 1'b1; sample_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         @(negedge clk);
         if (bfly_issue_3 && stage_count_3 == 3'd2 && iteration_count_3 == 4'd7) found = 1;
      end
      chk("wait_s2i7", 32'(found), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_all3", 32'(all3), 32'd0);
      chk("midrst_all0", 32'(all0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_nodone3", 32'(all3), 32'd0);
      chk("midrst_nodone0", 32'(all0), 32'd0);

      // full frame with both handshakes always ready
      out_ready = 1'b1; sample_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ld3 = 0; is3 = 0; gp3 = 0; ul3 = 0; dn3 = 0; is0 = 0; gp0 = 0; dn0 = 0;
      for (int c = 0; c < 400 && dn3 == 0; c++) begin
         if (input_mode_3 == 2'd1) ld3++;
         if (bfly_issue_3) is3++;
         if (input_mode_3 == 2'd2 && !bfly_issue_3) gp3++;
         if (input_mode_3 == 2'd3) begin
            chk("frame_ocnt3", 32'(samples_out_count_3), 32'(ul3));
            ul3++;
         end
         if (done_3) dn3++;
         if (bfly_issue_0) is0++;
         if (input_mode_0 == 2'd2 && !bfly_issue_0) gp0++;
         if (done_0) dn0++;
         @(negedge clk);
      end
      chk("frame_load3", 32'(ld3), 32'd32);
      chk("frame_issue3", 32'(is3), 32'd80);
      chk("frame_gap3", 32'(gp3), 32'd15);
      chk("frame_unload3", 32'(ul3), 32'd32);
      chk("frame_done3", 32'(dn3), 32'd1);
      chk("frame_issue0", 32'(is0), 32'd80);
      chk("frame_gap0", 32'(gp0), 32'd0);
      chk("frame_done0", 32'(dn0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
